// File: rtl/mem_access_unit.sv
// Load/store initiator between the datapath and a word-wide data memory.
// Big-endian lanes; sub-word stores use a read-modify-write through a merge register.
module mem_access_unit #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]    r_state;
  logic          r_we;
  logic [1:0]    r_size;
  logic          r_unsigned;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_merge;
  logic [31:0]   r_rdata;
  logic          r_err;

  logic          w_accept;
  logic          w_req_err;
  logic          w_subword_store;
  logic [1:0]    w_next_state;
  logic [7:0]    w_byte_lane;
  logic [15:0]   w_half_lane;
  logic [31:0]   w_load_data;
  logic [31:0]   w_merge_data;

  assign w_accept        = req_valid & req_ready;
  assign w_subword_store = r_we && (r_size != SZ_WORD);

  // Illegal size or misalignment is decided from the live request at accept time.
  always_comb begin
    w_req_err = 1'b0;
    case (req_size)
      SZ_BYTE: w_req_err = 1'b0;
      SZ_HALF: w_req_err = req_addr[0];
      SZ_WORD: w_req_err = (req_addr[1:0] != 2'b00);
      default: w_req_err = 1'b1;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next_state = w_req_err ? S_RESP : S_ACCESS;
      S_ACCESS: w_next_state = w_subword_store ? S_WRITE : S_RESP;
      S_WRITE:  w_next_state = S_RESP;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Lane selection: offset 0 is the most significant byte of the word.
  always_comb begin
    w_byte_lane = 8'h00;
    case (r_addr[1:0])
      2'd0:    w_byte_lane = mem_rd[31:24];
      2'd1:    w_byte_lane = mem_rd[23:16];
      2'd2:    w_byte_lane = mem_rd[15:8];
      default: w_byte_lane = mem_rd[7:0];
    endcase
    w_half_lane = r_addr[1] ? mem_rd[15:0] : mem_rd[31:16];
  end

  always_comb begin
    w_load_data = mem_rd;
    case (r_size)
      SZ_BYTE: w_load_data = r_unsigned ? {24'h000000, w_byte_lane}
                                        : {{24{w_byte_lane[7]}}, w_byte_lane};
      SZ_HALF: w_load_data = r_unsigned ? {16'h0000, w_half_lane}
                                        : {{16{w_half_lane[15]}}, w_half_lane};
      default: w_load_data = mem_rd;
    endcase
  end

  always_comb begin
    w_merge_data = mem_rd;
    if (r_size == SZ_BYTE) begin
      case (r_addr[1:0])
        2'd0:    w_merge_data[31:24] = r_wdata[7:0];
        2'd1:    w_merge_data[23:16] = r_wdata[7:0];
        2'd2:    w_merge_data[15:8]  = r_wdata[7:0];
        default: w_merge_data[7:0]   = r_wdata[7:0];
      endcase
    end else if (r_size == SZ_HALF) begin
      if (r_addr[1]) w_merge_data[15:0]  = r_wdata[15:0];
      else           w_merge_data[31:16] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
    end else if (w_accept) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
    end
  end

  // Response fields change only on the edge that enters RESP, so they hold in between.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_merge <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_req_err) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (w_subword_store) begin
            r_merge <= w_merge_data;
          end else begin
            r_rdata <= r_we ? 32'h0 : w_load_data;
            r_err   <= 1'b0;
          end
        end
        S_WRITE: begin
          r_rdata <= 32'h0;
          r_err   <= 1'b0;
        end
        default: begin
          r_rdata <= r_rdata;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  assign mem_we = ((r_state == S_ACCESS) && r_we && (r_size == SZ_WORD)) ||
                  (r_state == S_WRITE);
  assign mem_a  = {r_addr[AW-1:2], 2'b00};
  assign mem_wd = (r_state == S_WRITE) ? r_merge : r_wdata;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the MIPS datapath and the word-wide data memory. Accepts one byte, halfword or word load/store request at a time over a valid/ready handshake. Drives the memory's single word port: write on clock edge, combinational read. Performs sign/zero extension for loads, read-modify-write for sub-word stores, and flags misaligned accesses without touching memory.

## Interface
Parameters:
- AW, 32, request/memory address width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal-size request, qualified by rsp_valid
- mem_we  out  1  memory write enable
- mem_a  out  AW  memory byte address, low two bits always 0
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data, combinational from mem_a

## Operation
- Accept when req_valid & req_ready. Latch we, size, unsigned, addr, wdata.
- Lane order is big-endian:
  - byte offset 0 maps to bits [31:24], offset 3 to [7:0];
  - half offset 0 maps to [31:16], offset 2 to [15:0].
- Error check at accept:
  - size 11, half with addr[0]=1, or word with addr[1:0]≠0 is an error;
  - goes IDLE→RESP with rsp_err=1, rsp_rdata=0;
  - mem_we never asserted.
- FSM states: IDLE, ACCESS, WRITE, RESP.
  - IDLE: req_ready=1. On a legal accept go to ACCESS; on an error accept go to RESP.
  - ACCESS, load: select lane from mem_rd, extend to 32 bits, register into rsp_rdata, go to RESP.
  - ACCESS, word store: mem_we=1, mem_wd=wdata, go to RESP.
  - ACCESS, byte/half store: mem_we=0; register mem_rd with the target lane replaced by wdata into a merge register; go to WRITE.
  - WRITE: mem_we=1, mem_wd=merge register, go to RESP.
  - RESP: rsp_valid=1, go to IDLE.
- rsp_valid has no backpressure. The consumer must sample it in the RESP cycle.
- mem_a = {addr_q[AW-1:2],2'b00} in all states. mem_we is decoded combinationally from state.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE; all latched fields = 0;
  - req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_a=0, mem_wd=0.
- With the accept edge at cycle t:
  - load / word store: ACCESS in t+1, rsp_valid in t+2;
  - byte/half store: ACCESS t+1, WRITE t+2, rsp_valid t+3;
  - error: rsp_valid in t+1.
- req_ready=0 in ACCESS, WRITE and RESP. The next accept is the cycle after RESP. Minimum spacing is 3 cycles (load/sw) or 4 cycles (sb/sh).
- The memory word is written on the rising edge ending the ACCESS cycle (sw) or the WRITE cycle (sb/sh), exactly once per store.
- rsp_rdata and rsp_err hold their values until the next RESP. They are meaningful only while rsp_valid=1.
- Reset mid-operation:
  - FSM returns to IDLE and mem_we drops asynchronously;
  - a sub-word store interrupted in ACCESS or WRITE leaves the memory word unchanged;
  - no rsp_valid is issued for the aborted request.
- req_valid during a busy state is ignored. The requester holds the request until req_ready.

## Test plan
- Word load: memory word 0x10 = 0x8899AABB; lw 0x10 accepted at t. Expect mem_a=0x10, rsp_valid at t+2, rsp_rdata=0x8899AABB, rsp_err=0.
- Sub-word loads, same word:
  - lb 0x11 → 0xFFFFFF99; lbu 0x11 → 0x00000099;
  - lb 0x13 → 0xFFFFFFBB;
  - lh 0x12 → 0xFFFFAABB; lhu 0x10 → 0x00008899.
- Sub-word stores:
  - sb 0x13 with wdata 0x12345677: mem_we=1 only in t+2; word becomes 0x8899AA77; rsp_valid at t+3, rsp_rdata=0.
  - sh 0x10 with wdata 0x0000CAFE: word becomes 0xCAFEAA77.
  - sw 0x10 with wdata 0xDEADBEEF: mem_we in t+1, rsp at t+2.
- Errors: sh 0x11, lw 0x12, and size 11 at 0x10. Expect rsp_valid at t+1 with rsp_err=1, rsp_rdata=0, mem_we never high, memory unchanged.
- Reset mid-store: sh 0x10 with wdata 0x1234; assert reset_n=0 during the WRITE cycle. Expect mem_we low immediately, word unchanged, no rsp_valid, req_ready=1 after release.
- Back-to-back requests with req_valid held high (lw 0x10, then sb 0x14). Expect req_ready low for 2 (lw) then 3 (sb) cycles after each accept. Second accept occurs in the cycle after the first RESP; no request is lost or duplicated.
